board_reader: RTL and testbench

Snapshot reader for the 30x30 board memory. On a start pulse it sweeps every cell through the memory's second address port (`x_loc_sw`/`y_loc_sw`), reads each 2-bit cell, rebuilds the packed 1800-bit board vector in `snakeWriter`'s layout, and counts snake and food cells. It is the read-side counterpart of `snakeWriter`. Game logic uses it to verify the board and to derive score and length.

---
 rtl/snake_pkg.sv | 30 +++
 rtl/board_reader_if.sv | 21 ++
 rtl/grid_addr_counter.sv | 37 +++
 rtl/board_reader.sv | 106 ++++++++++
 tb/tb_board_reader.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared constants and types for the snake board memory, writer and reader.
// Cell codes and board packing must agree across all three blocks.
package snake_pkg;

    localparam int GRID_W     = 30;
    localparam int GRID_H     = 30;
    localparam int CELL_BITS  = 2;
    localparam int BOARD_BITS = GRID_W * GRID_H * CELL_BITS;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_SNAKE = 2'b01;
    localparam logic [1:0] CELL_FOOD  = 2'b10;
    localparam logic [1:0] CELL_WALL  = 2'b11;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_SCAN,
        RD_DRAIN,
        RD_DONE
    } rd_state_t;

    function automatic logic [9:0] cell_index(
        input logic [4:0] x,
        input logic [4:0] y,
        input int         w
    );
        return 10'(int'(y) * w + int'(x));
    endfunction

endpackage

// File: rtl/board_reader_if.sv
// Second read port of the board memory: cell address out, cell data back.
// Data follows its address by one clock.
interface board_reader_if;

    logic [4:0] x_loc;
    logic [4:0] y_loc;
    logic [1:0] data_in;

    modport master (
        output x_loc,
        output y_loc,
        input  data_in
    );

    modport slave (
        input  x_loc,
        input  y_loc,
        output data_in
    );

endinterface

// File: rtl/grid_addr_counter.sv
// Raster x/y cell counter, x fastest, wrapping at the grid edges.
// `last` flags the final cell so the owner can end its sweep.
module grid_addr_counter #(
    parameter int GRID_W = snake_pkg::GRID_W,
    parameter int GRID_H = snake_pkg::GRID_H
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    output logic [4:0] x,
    output logic [4:0] y,
    output logic       last
);

    logic x_end;
    logic y_end;

    assign x_end = (x == 5'(GRID_W - 1));
    assign y_end = (y == 5'(GRID_H - 1));
    assign last  = x_end && y_end;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x_end) begin
                x <= '0;
                y <= y_end ? 5'd0 : y + 5'd1;
            end else begin
                x <= x + 5'd1;
            end
        end
    end

endmodule

// File: rtl/board_reader.sv
// Sweeps the board memory once per start and rebuilds the packed board,
// counting snake and food cells along the way.
module board_reader #(
    parameter int GRID_W    = snake_pkg::GRID_W,
    parameter int GRID_H    = snake_pkg::GRID_H,
    parameter int CELL_BITS = snake_pkg::CELL_BITS
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    board_reader_if.master                      mem,
    output logic [GRID_W*GRID_H*CELL_BITS-1:0] board_out,
    output logic [9:0]                          snake_count,
    output logic [9:0]                          food_count,
    output logic                                busy,
    output logic                                done
);

    import snake_pkg::*;

    rd_state_t  state;
    rd_state_t  state_nxt;
    logic [4:0] x;
    logic [4:0] y;
    logic       last;
    logic       scan;
    logic       idle;
    logic [9:0] idx_d;
    logic       vld_d;

    assign scan      = (state == RD_SCAN);
    assign idle      = (state == RD_IDLE);
    assign mem.x_loc = x;
    assign mem.y_loc = y;

    grid_addr_counter #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_addr (
        .clk   (clk),
        .reset (reset),
        .clr   (idle),
        .en    (scan),
        .x     (x),
        .y     (y),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= RD_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            RD_IDLE: begin
                if (start) state_nxt = RD_SCAN;
            end
            RD_SCAN: begin
                busy = 1'b1;
                if (last) state_nxt = RD_DRAIN;
            end
            RD_DRAIN: begin
                busy      = 1'b1;
                state_nxt = RD_DONE;
            end
            RD_DONE: begin
                done      = 1'b1;
                state_nxt = RD_IDLE;
            end
            default: state_nxt = RD_IDLE;
        endcase
    end

    // Index issued last cycle pairs with the datum arriving this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_d       <= '0;
            vld_d       <= 1'b0;
            board_out   <= '0;
            snake_count <= '0;
            food_count  <= '0;
        end else begin
            idx_d <= cell_index(x, y, GRID_W);
            vld_d <= scan;
            if (idle && start) begin
                snake_count <= '0;
                food_count  <= '0;
            end
            if (vld_d) begin
                board_out[CELL_BITS*idx_d +: CELL_BITS] <= mem.data_in;
                unique case (1'b1)
                    (mem.data_in == CELL_SNAKE):
                        snake_count <= snake_count + 10'd1;
                    (mem.data_in == CELL_FOOD):
                        food_count <= food_count + 10'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_board_reader.sv
// Scoreboard bench for board_reader: stimulus pushes expected snapshots,
// a monitor pops and compares them on every done pulse.
module tb_board_reader;

    localparam int NB  = 1800;
    localparam int LAT = 901;

    typedef struct {
        int          e0;
        int          snake;
        int          food;
        logic [NB-1:0] board;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic [NB-1:0] board_out;
    logic [9:0]    snake_count;
    logic [9:0]    food_count;
    logic          busy;
    logic          done;

    board_reader_if mif ();

    board_reader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mem         (mif),
        .board_out   (board_out),
        .snake_count (snake_count),
        .food_count  (food_count),
        .busy        (busy),
        .done        (done)
    );

    exp_t q[$];
    int   n_chk;
    int   n_pass;
    int   n_done;
    int   cyc;
    int   mode;
    int   rk;
    int   raster_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: synchronous read, one cycle of latency.
    always @(posedge clk) begin
        if (mode == 0)
            mif.data_in <= 2'b01;
        else
            mif.data_in <= 2'((int'(mif.y_loc) * 30 + int'(mif.x_loc)) % 4);
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic chk_board(input string nm, input logic [NB-1:0] act,
                             input logic [NB-1:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            for (int i = 0; i < 900; i++) begin
                if (act[2*i +: 2] !== exp[2*i +: 2]) begin
                    $display("FAIL %s: cell %0d got %b expected %b",
                             nm, i, act[2*i +: 2], exp[2*i +: 2]);
                    break;
                end
            end
        end
    endtask

    function automatic logic [NB-1:0] ref_board(input int m);
        logic [NB-1:0] b;
        b = '0;
        for (int yy = 0; yy < 30; yy++)
            for (int xx = 0; xx < 30; xx++)
                b[2*(yy*30+xx) +: 2] =
                    (m == 0) ? 2'b01 : 2'((yy*30+xx) % 4);
        return b;
    endfunction

    // Raster-order monitor: every busy cycle before DRAIN shows cell rk.
    initial begin
        rk = 0;
        raster_err = 0;
    end
    always @(negedge clk) begin
        if (busy && !reset) begin
            if (rk < 900 &&
                (int'(mif.x_loc) != rk % 30 || int'(mif.y_loc) != rk / 30))
                raster_err++;
            rk++;
        end else begin
            rk = 0;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!reset && done) begin
            exp_t e;
            n_done++;
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                e = q.pop_front();
                chk("done_latency", cyc - e.e0, LAT);
                chk("snake_count", snake_count, e.snake);
                chk("food_count", food_count, e.food);
                chk_board("board_out", board_out, e.board);
            end
        end
    end

    task automatic push_exp(input int e0, input int m, input int s, input int f);
        exp_t e;
        e.e0    = e0;
        e.snake = s;
        e.food  = f;
        e.board = ref_board(m);
        q.push_back(e);
    endtask

    // Drive start for one edge; returns the cycle stamp of that edge (E0).
    task automatic kick(output int e0);
        start = 1'b1;
        @(negedge clk);
        e0 = cyc;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_empty(input string nm);
        int n;
        n = 0;
        while (q.size() != 0 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL %s_timeout: got %0d pending expected 0", nm, q.size());
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_x"}, mif.x_loc, 0);
        chk({nm, "_y"}, mif.y_loc, 0);
        chk({nm, "_snake"}, snake_count, 0);
        chk({nm, "_food"}, food_count, 0);
        chk({nm, "_board"}, (board_out == '0) ? 1 : 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int d0;
        n_chk  = 0;
        n_pass = 0;
        n_done = 0;
        mode   = 0;
        reset  = 1'b1;
        start  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        repeat (20) @(negedge clk);
        chk_reset_state("idle");

        // Uniform snake board.
        mode = 0;
        kick(e0);
        push_exp(e0, 0, 900, 0);
        wait_empty("uniform");

        // Index-pattern board, also checks raster order.
        mode = 1;
        kick(e0);
        push_exp(e0, 1, 225, 225);
        wait_empty("index");
        chk("raster_order", raster_err, 0);

        // Starts during a sweep are ignored.
        d0 = n_done;
        kick(e0);
        push_exp(e0, 1, 225, 225);
        repeat (299) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (299) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_empty("busy_start");
        repeat (20) @(negedge clk);
        chk("busy_start_done_pulses", n_done - d0, 1);

        // Reset mid-sweep aborts without a done.
        kick(e0);
        push_exp(e0, 1, 225, 225);
        repeat (449) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        chk_reset_state("mid_reset");
        d0 = n_done;
        repeat (1000) @(negedge clk);
        chk("mid_reset_no_done", n_done - d0, 0);
        kick(e0);
        push_exp(e0, 1, 225, 225);
        wait_empty("after_reset");

        // Back-to-back with start held high.
        mode = 0;
        start = 1'b1;
        @(negedge clk);
        e0 = cyc;
        push_exp(e0, 0, 900, 0);
        push_exp(e0 + 903, 0, 900, 0);
        while (cyc < e0 + 903) @(negedge clk);
        start = 1'b0;
        chk("b2b_busy_at_e903", busy, 1);
        chk("b2b_snake_clear", snake_count, 0);
        chk("b2b_food_clear", food_count, 0);
        wait_empty("b2b");
        chk("final_raster_order", raster_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
